min_uint64_serial: RTL



---
 rtl/min_uint64_serial.sv | 114 +++++++++++
 1 files changed

// File: rtl/min_uint64_serial.sv
// Bit-serial MSB-first unsigned minimum of two WIDTH-bit operands, STEP bits per cycle.
// Valid/ready on both sides; fixed latency of WIDTH/STEP scan cycles per operation.
module min_uint64_serial #(
    parameter int WIDTH = 64,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             lt
);

    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if (STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_step
            $error("min_uint64_serial: STEP must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt;
    logic             decided;
    logic             a_lt;

    logic [IDX_W-1:0] slice_idx;
    logic [STEP-1:0]  slice_a;
    logic [STEP-1:0]  slice_b;
    logic             a_lt_next;

    // The first differing slice (scanning from the MSB end) settles the order; later slices are ignored.
    always_comb begin
        slice_idx = IDX_W'(WIDTH - STEP * (int'(cnt) + 1));
        slice_a   = a_q[slice_idx +: STEP];
        slice_b   = b_q[slice_idx +: STEP];
        a_lt_next = a_lt;
        if (!decided && (slice_a != slice_b)) begin
            a_lt_next = (slice_a < slice_b);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Y         <= '0;
            lt        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            decided   <= 1'b0;
            a_lt      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        cnt      <= '0;
                        decided  <= 1'b0;
                        a_lt     <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    cnt  <= cnt + CNT_W'(1);
                    a_lt <= a_lt_next;
                    if (slice_a != slice_b) begin
                        decided <= 1'b1;
                    end
                    // Last slice: the result uses this cycle's decision, not the registered one.
                    if (cnt == LAST) begin
                        Y         <= a_lt_next ? a_q : b_q;
                        lt        <= a_lt_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
